// File: rtl/Falco_pkg.sv
// Falco_pkg: shared ROB types for the branch-miss recovery walker.
//   ROB_DEPTH        ROB entry count (power of two)
//   rob_tag_t        ROB slot index
//   rob_rd_entry_t   ROB read-port payload used by the walker
//   recovery_walk_state_t  walker FSM states
//   rob_dist(a,b,d)  (a - b) mod d for a power-of-two d
package Falco_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int PRF_DEPTH = 64;
  localparam int ARF_DEPTH = 32;

  typedef logic [$clog2(ROB_DEPTH)-1:0] rob_tag_t;
  typedef logic [$clog2(PRF_DEPTH)-1:0] prf_specifier_t;
  typedef logic [$clog2(ARF_DEPTH)-1:0] arf_specifier_t;

  typedef struct packed {
    logic           has_dest;
    arf_specifier_t arf;
    prf_specifier_t old_prf;
    logic           is_store;
    logic           finished;
  } rob_rd_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } recovery_walk_state_t;

  // Modular distance between two tags; the mask does the wrap, so callers
  // truncate the result to their own tag width.
  function automatic logic [31:0] rob_dist(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] depth);
    return (a - b) & (depth - 32'd1);
  endfunction

endpackage

// File: rtl/recovery_walk_ctrl_if.sv
// recovery_walk_ctrl_if: bundle between the ROB/rename side and the walker.
//   master: drives start_i, miss/tail/head tags and the ROB read data
//   slave : the walker; drives ROB read addresses, the two recovery ports,
//           busy/done/restore_tail/overrun_err
interface recovery_walk_ctrl_if #(
  parameter int TAG_W = $clog2(Falco_pkg::ROB_DEPTH)
);
  import Falco_pkg::*;

  logic             start_i;
  logic [TAG_W-1:0] miss_rob_tag;
  logic [TAG_W-1:0] tail_rob_tag;
  logic [TAG_W-1:0] head_rob_tag;

  logic [TAG_W-1:0] rd_tag_0;
  logic [TAG_W-1:0] rd_tag_1;
  rob_rd_entry_t    rd_entry_0;
  rob_rd_entry_t    rd_entry_1;

  prf_specifier_t   recovery_old_prf_0;
  prf_specifier_t   recovery_old_prf_1;
  arf_specifier_t   recovery_arf_0;
  arf_specifier_t   recovery_arf_1;
  logic             recovery_arf_map_0_valid;
  logic             recovery_arf_map_1_valid;
  logic             store_flush_0_valid;
  logic             store_flush_1_valid;

  logic             busy;
  logic             done;
  logic [TAG_W-1:0] restore_tail;
  logic             overrun_err;

  modport master (
    output start_i, miss_rob_tag, tail_rob_tag, head_rob_tag,
    output rd_entry_0, rd_entry_1,
    input  rd_tag_0, rd_tag_1,
    input  recovery_old_prf_0, recovery_old_prf_1,
    input  recovery_arf_0, recovery_arf_1,
    input  recovery_arf_map_0_valid, recovery_arf_map_1_valid,
    input  store_flush_0_valid, store_flush_1_valid,
    input  busy, done, restore_tail, overrun_err
  );

  modport slave (
    input  start_i, miss_rob_tag, tail_rob_tag, head_rob_tag,
    input  rd_entry_0, rd_entry_1,
    output rd_tag_0, rd_tag_1,
    output recovery_old_prf_0, recovery_old_prf_1,
    output recovery_arf_0, recovery_arf_1,
    output recovery_arf_map_0_valid, recovery_arf_map_1_valid,
    output store_flush_0_valid, store_flush_1_valid,
    output busy, done, restore_tail, overrun_err
  );

endinterface

// File: rtl/recovery_walk_ctrl.sv
// recovery_walk_ctrl: walks the ROB from the youngest entry back to (but not
// including) a mispredicted branch, two entries per cycle, emitting the
// old-PRF / ARF pairs to restore the rename map and store-flush indications.
// Port 0 is always the older of the two entries read in a cycle.
//
// Ports:
//   clk  core clock
//   rst  synchronous active-high reset
//   bus  recovery_walk_ctrl_if.slave (start/tags in, ROB reads, recovery
//        ports, busy/done/restore_tail/overrun_err out)
//
// Build option: RECOVERY_WALK_RETARGET_EN -- when defined, a start_i during a
// walk for an older branch retargets the running walk instead of flagging
// overrun_err; head_rob_tag is only used in that build.
module recovery_walk_ctrl #(
  parameter int ROB_DEPTH = Falco_pkg::ROB_DEPTH,
  parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
  input logic                clk,
  input logic                rst,
  recovery_walk_ctrl_if.slave bus
);
  import Falco_pkg::*;

  localparam int CNT_W = TAG_W + 1;
  localparam logic [CNT_W-1:0] REM_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] REM_TWO = CNT_W'(2);

  recovery_walk_state_t r_state, w_state_next;
  logic [TAG_W-1:0] r_ptr;
  logic [TAG_W-1:0] r_target;
  logic [CNT_W-1:0] r_remaining;
  logic             r_overrun;

  logic [TAG_W-1:0] w_squash_cnt;
  logic [CNT_W-1:0] w_remaining_next;
  logic [CNT_W-1:0] w_extend;
  logic             w_pair;
  logic             w_retarget;
  logic             w_overrun_next;

  // Entries strictly between the miss and the tail: tail - miss - 1, wrapped.
  assign w_squash_cnt = TAG_W'(rob_dist(32'(bus.tail_rob_tag),
                                        32'(bus.miss_rob_tag) + 32'd1,
                                        32'(ROB_DEPTH)));

  assign w_pair = (r_remaining >= REM_TWO);

`ifdef RECOVERY_WALK_RETARGET_EN
  logic [TAG_W-1:0] w_miss_age;
  logic [TAG_W-1:0] w_target_age;

  // Age is distance from head: a smaller age is an older branch.
  assign w_miss_age   = TAG_W'(rob_dist(32'(bus.miss_rob_tag),
                                        32'(bus.head_rob_tag), 32'(ROB_DEPTH)));
  assign w_target_age = TAG_W'(rob_dist(32'(r_target),
                                        32'(bus.head_rob_tag), 32'(ROB_DEPTH)));
  assign w_retarget   = (r_state == WALK) && bus.start_i &&
                        (w_miss_age < w_target_age);
  // The older miss extends the walk by exactly the entries between it and
  // the old target.
  assign w_extend       = w_retarget ? {1'b0, w_target_age - w_miss_age} : '0;
  assign w_overrun_next = (r_state == DONE) && bus.start_i;
`else
  logic w_unused_head;
  assign w_unused_head  = ^bus.head_rob_tag;
  assign w_retarget     = 1'b0;
  assign w_extend       = '0;
  assign w_overrun_next = (r_state != IDLE) && bus.start_i;
`endif

  assign w_remaining_next = r_remaining - (w_pair ? REM_TWO : REM_ONE) + w_extend;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start_i) begin
          w_state_next = (w_squash_cnt != '0) ? WALK : DONE;
        end
      end
      WALK: begin
        if (w_remaining_next == '0) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Walk pointer, target and remaining count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_target    <= '0;
      r_remaining <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= w_overrun_next;
      case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_ptr       <= bus.tail_rob_tag - 1'b1;
            r_target    <= bus.miss_rob_tag;
            r_remaining <= {1'b0, w_squash_cnt};
          end
        end
        WALK: begin
          r_ptr       <= r_ptr - (w_pair ? TAG_W'(2) : TAG_W'(1));
          r_remaining <= w_remaining_next;
          if (w_retarget) begin
            r_target <= bus.miss_rob_tag;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs. Recovery ports are a zero-latency decode of the same-cycle ROB
  // read data; everything is forced low while rst is asserted.
  always_comb begin
    bus.rd_tag_0                 = '0;
    bus.rd_tag_1                 = '0;
    bus.recovery_old_prf_0       = '0;
    bus.recovery_old_prf_1       = '0;
    bus.recovery_arf_0           = '0;
    bus.recovery_arf_1           = '0;
    bus.recovery_arf_map_0_valid = 1'b0;
    bus.recovery_arf_map_1_valid = 1'b0;
    bus.store_flush_0_valid      = 1'b0;
    bus.store_flush_1_valid      = 1'b0;
    bus.busy                     = 1'b0;
    bus.done                     = 1'b0;
    bus.restore_tail             = '0;
    bus.overrun_err              = 1'b0;
    if (!rst) begin
      bus.overrun_err = r_overrun;
      case (r_state)
        WALK: begin
          bus.busy = 1'b1;
          // With two or more left, ptr is the younger entry (port 1).
          bus.rd_tag_0 = w_pair ? (r_ptr - 1'b1) : r_ptr;
          bus.recovery_old_prf_0       = bus.rd_entry_0.old_prf;
          bus.recovery_arf_0           = bus.rd_entry_0.arf;
          bus.recovery_arf_map_0_valid = bus.rd_entry_0.has_dest;
          bus.store_flush_0_valid      = bus.rd_entry_0.is_store & bus.rd_entry_0.finished;
          if (w_pair) begin
            bus.rd_tag_1                 = r_ptr;
            bus.recovery_old_prf_1       = bus.rd_entry_1.old_prf;
            bus.recovery_arf_1           = bus.rd_entry_1.arf;
            bus.recovery_arf_map_1_valid = bus.rd_entry_1.has_dest;
            bus.store_flush_1_valid      = bus.rd_entry_1.is_store & bus.rd_entry_1.finished;
          end
        end
        DONE: begin
          bus.busy         = 1'b1;
          bus.done         = 1'b1;
          bus.restore_tail = r_target + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_recovery_walk_ctrl.sv
module tb_recovery_walk_ctrl;
  import Falco_pkg::*;

  localparam int DEPTH = 32;

  typedef struct {
    int tail;
    int miss;
    int exp_cycles;
    int exp_restore;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  recovery_walk_ctrl_if bus ();

  recovery_walk_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural ROB: same-cycle read of whatever the walker addresses.
  rob_rd_entry_t rob_mem [DEPTH];
  assign bus.rd_entry_0 = rob_mem[bus.rd_tag_0];
  assign bus.rd_entry_1 = rob_mem[bus.rd_tag_1];

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [12:0] port_exp(input rob_rd_entry_t e, input bit act);
    if (!act) return '0;
    return {e.has_dest, e.is_store & e.finished, e.old_prf, e.arf};
  endfunction

  function automatic logic [12:0] port0_got();
    return {bus.recovery_arf_map_0_valid, bus.store_flush_0_valid,
            bus.recovery_old_prf_0, bus.recovery_arf_0};
  endfunction

  function automatic logic [12:0] port1_got();
    return {bus.recovery_arf_map_1_valid, bus.store_flush_1_valid,
            bus.recovery_old_prf_1, bus.recovery_arf_1};
  endfunction

  function automatic logic [63:0] all_out();
    return 64'({bus.busy, bus.done, bus.overrun_err, bus.rd_tag_0, bus.rd_tag_1,
                bus.restore_tail, port0_got(), port1_got()});
  endfunction

  task automatic randomize_rob();
    logic [12:0] tmp;
    for (int i = 0; i < DEPTH; i++) begin
      tmp = 13'($urandom);
      rob_mem[i] = tmp;
    end
  endtask

  // One full recovery from IDLE. The model is the list of squashed tags,
  // youngest first; each walk cycle consumes up to two of them.
  task automatic run_walk(input int tail, input int miss, input int exp_cyc,
                          input int exp_rt, input string lbl);
    int q[$];
    int n;
    int c;
    int t0;
    int t1;
    bit two;
    n = (tail - miss - 1) & (DEPTH - 1);
    for (int i = 0; i < n; i++) q.push_back((tail - 1 - i) & (DEPTH - 1));
    @(negedge clk);
    bus.start_i      = 1'b1;
    bus.tail_rob_tag = 5'(tail);
    bus.miss_rob_tag = 5'(miss);
    @(negedge clk);
    bus.start_i = 1'b0;
    c = 0;
    while (bus.busy && !bus.done && c < 40) begin
      if (q.size() == 0) break;
      two = (q.size() >= 2);
      if (two) begin
        t1 = q.pop_front();
        t0 = q.pop_front();
      end else begin
        t0 = q.pop_front();
        t1 = 0;
      end
      check({lbl, " rd_tag_0"}, 64'(bus.rd_tag_0), 64'(t0));
      if (two) check({lbl, " rd_tag_1"}, 64'(bus.rd_tag_1), 64'(t1));
      check({lbl, " port0"}, 64'(port0_got()), 64'(port_exp(rob_mem[t0], 1'b1)));
      check({lbl, " port1"}, 64'(port1_got()), 64'(port_exp(rob_mem[t1], two)));
      check({lbl, " overrun_in_walk"}, 64'(bus.overrun_err), 64'(0));
      c++;
      @(negedge clk);
    end
    check({lbl, " walk_cycles"}, 64'(c), 64'(exp_cyc));
    check({lbl, " walk_cycles_model"}, 64'(c), 64'((n + 1) / 2));
    check({lbl, " done"}, 64'({bus.busy, bus.done}), 64'(2'b11));
    check({lbl, " restore_tail"}, 64'(bus.restore_tail), 64'(exp_rt));
    check({lbl, " restore_tail_model"}, 64'(bus.restore_tail), 64'((miss + 1) & (DEPTH - 1)));
    $display("[TB] walk %s tail=%0d miss=%0d squashed=%0d cycles=%0d restore_tail=%0d",
             lbl, tail, miss, n, c, bus.restore_tail);
    @(negedge clk);
    check({lbl, " back_to_idle"}, 64'({bus.busy, bus.done}), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    int exp_c;
    int exp_rt;
    int tail;
    int miss;

    bus.start_i      = 1'b0;
    bus.miss_rob_tag = '0;
    bus.tail_rob_tag = '0;
    bus.head_rob_tag = '0;
    randomize_rob();

    // Reset: outputs quiet during and after.
    repeat (3) @(negedge clk);
    check("reset_outputs", all_out(), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", all_out(), 64'(0));
    $display("[TB] reset released, outputs idle");

    // Directed table.
    vecs = '{'{10, 4, 3, 5}, '{2, 29, 2, 30}, '{7, 6, 0, 7}, '{7, 5, 1, 6},
             '{0, 31, 0, 0}, '{5, 5, 16, 6}, '{31, 0, 15, 1}, '{20, 15, 2, 16}};
    // Finished store without a destination on the single entry of vecs[3].
    rob_mem[6] = '{has_dest: 1'b0, arf: 5'd3, old_prf: 6'd9, is_store: 1'b1, finished: 1'b1};
    for (int i = 0; i < 8; i++) begin
      run_walk(vecs[i].tail, vecs[i].miss, vecs[i].exp_cycles, vecs[i].exp_restore,
               $sformatf("vec%0d", i));
    end

    // Randomised walks against the list model.
    for (int k = 0; k < 30; k++) begin
      randomize_rob();
      tail = int'($urandom_range(0, DEPTH - 1));
      miss = int'($urandom_range(0, DEPTH - 1));
      run_walk(tail, miss, (((tail - miss - 1) & (DEPTH - 1)) + 1) / 2,
               (miss + 1) & (DEPTH - 1), $sformatf("rnd%0d", k));
    end

    // Nested miss during the first walk cycle.
    bus.head_rob_tag = 5'd0;
    @(negedge clk);
    bus.start_i      = 1'b1;
    bus.tail_rob_tag = 5'd20;
    bus.miss_rob_tag = 5'd15;
    @(negedge clk);
    check("nested walk_started", 64'({bus.busy, bus.done}), 64'(2'b10));
    bus.miss_rob_tag = 5'd10;
    @(negedge clk);
    bus.start_i = 1'b0;
    c = 1;
`ifdef RECOVERY_WALK_RETARGET_EN
    check("nested overrun_err", 64'(bus.overrun_err), 64'(0));
    exp_c  = 5;
    exp_rt = 11;
`else
    check("nested overrun_err", 64'(bus.overrun_err), 64'(1));
    exp_c  = 2;
    exp_rt = 16;
`endif
    while (bus.busy && !bus.done && c < 40) begin
      c++;
      @(negedge clk);
    end
    check("nested walk_cycles", 64'(c), 64'(exp_c));
    check("nested done", 64'(bus.done), 64'(1));
    check("nested restore_tail", 64'(bus.restore_tail), 64'(exp_rt));
    $display("[TB] nested miss: cycles=%0d restore_tail=%0d", c, bus.restore_tail);
    @(negedge clk);
    check("nested back_to_idle", 64'({bus.busy, bus.done, bus.overrun_err}), 64'(0));

    // start_i while in DONE is refused and flagged.
    bus.start_i      = 1'b1;
    bus.tail_rob_tag = 5'd7;
    bus.miss_rob_tag = 5'd6;
    @(negedge clk);
    check("done_start done", 64'({bus.done, bus.restore_tail}), 64'({1'b1, 5'd7}));
    @(negedge clk);
    bus.start_i = 1'b0;
    check("done_start overrun_err", 64'({bus.overrun_err, bus.busy}), 64'(2'b10));
    @(negedge clk);
    check("done_start quiet", all_out(), 64'(0));
    $display("[TB] start during DONE: overrun flagged, request ignored");

    // Reset in the second walk cycle abandons the walk.
    bus.start_i      = 1'b1;
    bus.tail_rob_tag = 5'd10;
    bus.miss_rob_tag = 5'd4;
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    check("rst_mid walk_active", 64'({bus.busy, bus.rd_tag_1}), 64'({1'b1, 5'd7}));
    rst = 1'b1;
    #1;
    check("rst_mid during_reset", all_out(), 64'(0));
    @(negedge clk);
    check("rst_mid after_edge", all_out(), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_mid no_done_%0d", i), all_out(), 64'(0));
    end
    $display("[TB] reset mid-walk: walk abandoned, no done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/recovery_walk_ctrl.md
RECOVERY_WALK_CTRL -- requirements
Module: recovery_walk_ctrl

Interface
REQ-001 Parameter ROB_DEPTH, default 32 from Falco_pkg, ROB entry count, power of two.
REQ-002 Parameter TAG_W, default $clog2(ROB_DEPTH), width of rob_tag_t.
REQ-003 Single clock; reset synchronous, active-high: clk  in  1  core clock; rst  in  1  sync reset.
REQ-004 start_i  in  1  branch-miss recovery request; miss_rob_tag  in  TAG_W  mispredicted branch tag; tail_rob_tag  in  TAG_W  next free ROB slot; head_rob_tag  in  TAG_W  oldest ROB entry.
REQ-005 rd_tag_0/rd_tag_1  out  TAG_W  ROB read addresses; same-cycle read data returns as rob_rd_entry_t rd_entry_0/rd_entry_1  in  {has_dest, arf, old_prf, is_store, finished}.
REQ-006 recovery_old_prf_0/1  out  prf_specifier_t; recovery_arf_0/1  out  arf_specifier_t; recovery_arf_map_0/1_valid  out  1; store_flush_0/1_valid  out  1. Port 0 is older than port 1; RNDS applies port 0 last.
REQ-007 busy  out  1  walk in progress, ROB stalls allocate/commit; done  out  1  one-cycle pulse; restore_tail  out  TAG_W  new ROB tail, valid with done; overrun_err  out  1  one-cycle pulse.

Function
REQ-008 FSM states IDLE, WALK, DONE; IDLE -> WALK on start_i when squash count > 0; IDLE -> DONE on start_i when count = 0; WALK -> DONE when remaining reaches 0 at end of a cycle; DONE -> IDLE always.
REQ-009 Squash count = (tail_rob_tag - miss_rob_tag - 1) mod ROB_DEPTH, computed in TAG_W bits with wrap; held in a TAG_W+1-bit remaining counter.
REQ-010 On start, walk pointer ptr <= tail_rob_tag - 1 (mod ROB_DEPTH); target <= miss_rob_tag.
REQ-011 In WALK with remaining >= 2: rd_tag_1 = ptr, rd_tag_0 = ptr - 1; both ports active; ptr -= 2; remaining -= 2.
REQ-012 In WALK with remaining = 1: rd_tag_0 = ptr, port 0 active, port 1 all valids 0; remaining <= 0.
REQ-013 Active port k: recovery_arf_map_k_valid = has_dest; store_flush_k_valid = is_store & finished; recovery_old_prf_k / recovery_arf_k driven from the entry; inactive ports drive 0 on all outputs.
REQ-014 Outputs combinational from read data, qualified by state = WALK; zero latency from read to recovery port.
REQ-015 busy = 1 in WALK and DONE; done = 1 and restore_tail = target + 1 only in DONE.
REQ-016 start_i in WALK or DONE without REQ-022 feature: ignored, overrun_err pulses next cycle.
REQ-017 start_i in IDLE: first walk cycle is cycle after start; walk of N entries finishes in ceil(N/2) cycles; done at cycle ceil(N/2)+1 after start.

Reset
REQ-018 rst forces IDLE in the next cycle; ptr, target, remaining cleared to 0.
REQ-019 During and after reset: all recovery/store_flush valids, busy, done, overrun_err = 0; rd_tag_0/1 = 0; restore_tail = 0.
REQ-020 rst mid-walk abandons walk without done pulse.

Configuration
REQ-021 Macro RECOVERY_WALK_RETARGET_EN selects nested-miss handling.
REQ-022 Defined: start_i in WALK with (miss_rob_tag - head_rob_tag) mod ROB_DEPTH < (target - head_rob_tag) mod ROB_DEPTH sets target <= miss_rob_tag, remaining += that distance difference, no overrun_err; younger or equal miss ignored silently; start_i in DONE -> overrun_err.
REQ-023 Undefined: REQ-016 applies; head_rob_tag unused.

Structure
REQ-024 Falco_pkg holds ROB_DEPTH, rob_tag_t, rob_rd_entry_t, and enum recovery_walk_state_t.
REQ-025 Single module, no sub-modules; modulo tag arithmetic in a package function rob_dist(a,b).

Verification
REQ-026 DEPTH 32, tail=10, miss=4 -> walk cycles (8,9),(6,7),(5,-); done next cycle, restore_tail=5.
REQ-027 Wrap: tail=2, miss=29 -> (0,1),(30,31); done, restore_tail=30.
REQ-028 miss=tail-1 (tail=7, miss=6) -> no valids, done one cycle after start, restore_tail=7.
REQ-029 Entry has_dest=0, is_store=1, finished=1 -> arf_map_valid=0, store_flush_valid=1 on that port.
REQ-030 head=0, tail=20, miss=15, then start miss=10 in first walk cycle -> macro on: walk continues to entry 11, restore_tail=11; macro off: overrun_err pulse, restore_tail=16.
REQ-031 rst asserted second walk cycle -> next cycle IDLE, all outputs 0, no done.
